// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter that sequences read/write commands onto the
// 32x8 single-port lab RAM and returns read data with a one-cycle rvalid pulse.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_w,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  logic last;
  logic rd0, rd1;
  logic elig0, elig1;
  logic win0, win1;

  // A requester granted this cycle is masked: it only drops req after seeing gnt.
  always_comb begin
    elig0 = req0 & ~gnt0;
    elig1 = req1 & ~gnt1;
    win0  = elig0 & (~elig1 | last);
    win1  = elig1 & (~elig0 | ~last);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last      <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      ram_w     <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      ram_raddr <= '0;
      rd0       <= 1'b0;
      rd1       <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      gnt0  <= win0;
      gnt1  <= win1;
      busy  <= win0 | win1;
      ram_w <= (win0 & we0) | (win1 & we1);
      rd0   <= win0 & ~we0;
      rd1   <= win1 & ~we1;

      if (win0) begin
        last <= 1'b0;
        if (we0) begin
          ram_waddr <= addr0;
          ram_wdata <= wdata0;
        end else begin
          ram_raddr <= addr0;
        end
      end else if (win1) begin
        last <= 1'b1;
        if (we1) begin
          ram_waddr <= addr1;
          ram_wdata <= wdata1;
        end else begin
          ram_raddr <= addr1;
        end
      end

      // Read data is captured at the edge that ends the issue cycle.
      rvalid0 <= rd0;
      rvalid1 <= rd1;
      if (rd0) rdata0 <= ram_rdata;
      if (rd1) rdata1 <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, shadow memory and
// per-requester read-data queues checked against rvalid pulses.
module tb_ram_arbiter;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1, ram_w, busy;
  logic [DATA_W-1:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_w(ram_w), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .busy(busy)
  );

  logic [DATA_W-1:0] mem     [2**ADDR_W];
  logic [DATA_W-1:0] ref_mem [2**ADDR_W];
  logic [DATA_W-1:0] q0[$], q1[$];
  int n_chk = 0;
  int n_pass = 0;

  always @(posedge clk) if (ram_w) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pushes expected read data at grant, pops and compares on rvalid.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (rvalid0) begin
        check("rv0_expected", 32'(q0.size() != 0), 32'(1));
        if (q0.size() != 0) check("rdata0", 32'(rdata0), 32'(q0.pop_front()));
      end
      if (rvalid1) begin
        check("rv1_expected", 32'(q1.size() != 0), 32'(1));
        if (q1.size() != 0) check("rdata1", 32'(rdata1), 32'(q1.pop_front()));
      end
      check("one_gnt", 32'(gnt0 && gnt1), 32'(0));
      check("ram_w", 32'(ram_w), 32'((gnt0 && we0) || (gnt1 && we1)));
      check("busy", 32'(busy), 32'(gnt0 || gnt1));
      if (gnt0) begin
        if (we0) begin
          check("waddr0", 32'(ram_waddr), 32'(addr0));
          check("wdata0", 32'(ram_wdata), 32'(wdata0));
          ref_mem[addr0] = wdata0;
        end else begin
          check("raddr0", 32'(ram_raddr), 32'(addr0));
          q0.push_back(ref_mem[addr0]);
        end
      end
      if (gnt1) begin
        if (we1) begin
          check("waddr1", 32'(ram_waddr), 32'(addr1));
          check("wdata1", 32'(ram_wdata), 32'(wdata1));
          ref_mem[addr1] = wdata1;
        end else begin
          check("raddr1", 32'(ram_raddr), 32'(addr1));
          q1.push_back(ref_mem[addr1]);
        end
      end
    end
  end

  // Drives one command, waits (bounded) for gnt, holds through the gnt cycle.
  task automatic do_cmd(input int p, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output int lat);
    if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if ((p == 0) ? gnt0 : gnt1) begin
        lat = i;
        break;
      end
    end
    step();
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  initial begin
    int l0, l1;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset and idle
    repeat (2) step();
    check("rst_gnt0", 32'(gnt0), 32'(0));
    check("rst_gnt1", 32'(gnt1), 32'(0));
    check("rst_rvalid", 32'({rvalid0, rvalid1}), 32'(0));
    check("rst_rdata", 32'({rdata0, rdata1}), 32'(0));
    check("rst_ram_w", 32'(ram_w), 32'(0));
    check("rst_ram_addr", 32'({ram_waddr, ram_raddr}), 32'(0));
    check("rst_ram_wdata", 32'(ram_wdata), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_gnt", 32'({gnt0, gnt1}), 32'(0));
      check("idle_busy", 32'(busy), 32'(0));
    end

    // Single write then read
    do_cmd(0, 1'b1, 5'd3, 8'h2A, l0);
    check("wr_lat", 32'(l0), 32'(1));
    check("wr_once", 32'(ram_w), 32'(0));
    do_cmd(0, 1'b0, 5'd3, 8'h00, l0);
    check("rd_gnt_lat", 32'(l0), 32'(1));
    check("rd_rvalid_lat", 32'(rvalid0), 32'(1));
    check("rd_data", 32'(rdata0), 32'(8'h2A));

    // Simultaneous requests after reset
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    fork
      do_cmd(0, 1'b1, 5'd0, 8'h10, l0);
      do_cmd(1, 1'b1, 5'd1, 8'h20, l1);
    join
    check("sim_lat0", 32'(l0), 32'(1));
    check("sim_lat1", 32'(l1), 32'(2));
    do_cmd(0, 1'b0, 5'd0, 8'h00, l0);
    check("sim_rd0", 32'(rdata0), 32'(8'h10));
    do_cmd(1, 1'b0, 5'd1, 8'h00, l1);
    check("sim_rd1", 32'(rdata1), 32'(8'h20));

    // Fairness: both held high, grants alternate starting with requester 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("fair_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      check("fair_gnt1", 32'(gnt1), 32'(i % 2 == 1));
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) step();

    // Single requester back-to-back reads
    do_cmd(1, 1'b1, 5'd2, 8'h30, l1);
    do_cmd(1, 1'b1, 5'd3, 8'h40, l1);
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
    step();
    check("b2b_g1", 32'(gnt1), 32'(1));
    step();
    check("b2b_g2", 32'(gnt1), 32'(0));
    check("b2b_rv1", 32'(rvalid1), 32'(1));
    check("b2b_d1", 32'(rdata1), 32'(8'h30));
    addr1 = 5'd3;
    step();
    check("b2b_g3", 32'(gnt1), 32'(1));
    check("b2b_rv_gap", 32'(rvalid1), 32'(0));
    step();
    check("b2b_g4", 32'(gnt1), 32'(0));
    check("b2b_rv2", 32'(rvalid1), 32'(1));
    check("b2b_d2", 32'(rdata1), 32'(8'h40));
    req1 = 1'b0;
    repeat (2) step();

    // Reset during the issue cycle of a read
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1;
    step();
    check("mr_gnt", 32'(gnt0), 32'(1));
    rst_n = 1'b0;
    req0 = 1'b0;
    step();
    check("mr_rvalid", 32'(rvalid0), 32'(0));
    check("mr_rdata", 32'(rdata0), 32'(0));
    check("mr_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mr_no_rvalid", 32'(rvalid0), 32'(0));
    end

    check("q0_drained", 32'(q0.size()), 32'(0));
    check("q1_drained", 32'(q1.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
